// File: rtl/vector_subtraction_pipe.sv
// vector_subtraction_pipe: two-stage, valid/ready handshaked subtractor for
// packed vectors of NUM_COMP signed COMP_W-bit components (x in the LSBs).
// out_vector = in_vector_1 - in_vector_2 per component, with per-component
// signed overflow flags, a sticky overflow bit and a delivered-vector counter.
// Optional build macro: VECTOR_SUB_SATURATE_EN. When it is defined,
// overflowing components saturate instead of wrapping.
module vector_subtraction_pipe #(
  parameter int COMP_W   = 19,
  parameter int NUM_COMP = 3,
  parameter int CNT_W    = 16,
  localparam int VEC_W   = COMP_W * NUM_COMP
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [VEC_W-1:0]    in_vector_1,
  input  logic [VEC_W-1:0]    in_vector_2,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [VEC_W-1:0]    out_vector,
  output logic [NUM_COMP-1:0] out_ovf,
  output logic                ovf_sticky,
  input  logic                clr_sticky,
  output logic [CNT_W-1:0]    vec_count
);

  logic                s1_valid_reg;
  logic [VEC_W-1:0]    s1_a_reg;
  logic [VEC_W-1:0]    s1_b_reg;
  logic                s2_valid_reg;
  logic [VEC_W-1:0]    s2_diff_reg;
  logic [NUM_COMP-1:0] s2_ovf_reg;
  logic                ovf_sticky_reg;
  logic [CNT_W-1:0]    vec_count_reg;

  logic                en1;
  logic                en2;
  logic                xfer;
  logic [VEC_W-1:0]    diff_next;
  logic [NUM_COMP-1:0] ovf_next;

  // A stage may advance when it is empty or the stage after it is moving.
  assign en2      = !s2_valid_reg || out_ready;
  assign en1      = !s1_valid_reg || en2;
  assign in_ready = en1;
  assign xfer     = s2_valid_reg && out_ready;

  // Per-component subtract on one extra bit; the top two bits disagree
  // exactly when the true difference does not fit in COMP_W bits.
  for (genvar gi = 0; gi < NUM_COMP; gi++) begin : g_comp
    logic signed [COMP_W:0] a_ext;
    logic signed [COMP_W:0] b_ext;
    logic signed [COMP_W:0] d;

    assign a_ext = {s1_a_reg[gi*COMP_W + COMP_W-1], s1_a_reg[gi*COMP_W +: COMP_W]};
    assign b_ext = {s1_b_reg[gi*COMP_W + COMP_W-1], s1_b_reg[gi*COMP_W +: COMP_W]};
    assign d     = a_ext - b_ext;
    assign ovf_next[gi] = d[COMP_W] ^ d[COMP_W-1];

`ifdef VECTOR_SUB_SATURATE_EN
    // The extra sign bit tells which rail to clamp to.
    assign diff_next[gi*COMP_W +: COMP_W] =
      !ovf_next[gi] ? d[COMP_W-1:0] :
      (d[COMP_W] ? {1'b1, {(COMP_W-1){1'b0}}} : {1'b0, {(COMP_W-1){1'b1}}});
`else
    assign diff_next[gi*COMP_W +: COMP_W] = d[COMP_W-1:0];
`endif
  end

  // Stage 1: capture the operand pair on an accepted input.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_reg <= 1'b0;
      s1_a_reg     <= '0;
      s1_b_reg     <= '0;
    end else if (en1) begin
      s1_valid_reg <= in_valid;
      if (in_valid) begin
        s1_a_reg <= in_vector_1;
        s1_b_reg <= in_vector_2;
      end
    end
  end

  // Stage 2: register the difference and flags; data only moves with a valid
  // vector so the held output stays put across bubbles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s2_valid_reg <= 1'b0;
      s2_diff_reg  <= '0;
      s2_ovf_reg   <= '0;
    end else if (en2) begin
      s2_valid_reg <= s1_valid_reg;
      if (s1_valid_reg) begin
        s2_diff_reg <= diff_next;
        s2_ovf_reg  <= ovf_next;
      end
    end
  end

  // Status: count completed transfers; an overflowing transfer beats a clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ovf_sticky_reg <= 1'b0;
      vec_count_reg  <= '0;
    end else begin
      if (xfer) begin
        vec_count_reg <= vec_count_reg + 1'b1;
      end
      if (xfer && (|s2_ovf_reg)) begin
        ovf_sticky_reg <= 1'b1;
      end else if (clr_sticky) begin
        ovf_sticky_reg <= 1'b0;
      end
    end
  end

  assign out_valid  = s2_valid_reg;
  assign out_vector = s2_diff_reg;
  assign out_ovf    = s2_ovf_reg;
  assign ovf_sticky = ovf_sticky_reg;
  assign vec_count  = vec_count_reg;

endmodule

// File: tb/tb_vector_subtraction_pipe.sv
// Scoreboard bench for vector_subtraction_pipe: the driver pushes the
// reference result of every accepted vector pair, a monitor pops and compares
// on each completed output handshake and tracks the expected count/sticky.
module tb_vector_subtraction_pipe;
  localparam int COMP_W   = 19;
  localparam int NUM_COMP = 3;
  localparam int CNT_W    = 16;
  localparam int VEC_W    = COMP_W * NUM_COMP;
  localparam int MAXV     = (1 << (COMP_W-1)) - 1;
  localparam int MINV     = -(1 << (COMP_W-1));

  typedef struct packed {
    logic [VEC_W-1:0]    vec;
    logic [NUM_COMP-1:0] ovf;
  } exp_t;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                in_valid = 1'b0;
  logic                in_ready;
  logic [VEC_W-1:0]    in_vector_1 = '0;
  logic [VEC_W-1:0]    in_vector_2 = '0;
  logic                out_valid;
  logic                out_ready = 1'b1;
  logic [VEC_W-1:0]    out_vector;
  logic [NUM_COMP-1:0] out_ovf;
  logic                ovf_sticky;
  logic                clr_sticky = 1'b0;
  logic [CNT_W-1:0]    vec_count;

  int checks = 0;
  int errors = 0;
  exp_t q[$];
  logic [CNT_W-1:0] exp_count = '0;
  logic             exp_sticky = 1'b0;
  bit               rand_done;

  vector_subtraction_pipe #(.COMP_W(COMP_W), .NUM_COMP(NUM_COMP), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_vector_1(in_vector_1), .in_vector_2(in_vector_2),
    .out_valid(out_valid), .out_ready(out_ready), .out_vector(out_vector),
    .out_ovf(out_ovf), .ovf_sticky(ovf_sticky), .clr_sticky(clr_sticky),
    .vec_count(vec_count)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [VEC_W-1:0] pack(input int x, input int y, input int z);
    logic [VEC_W-1:0] v;
    v = {z[COMP_W-1:0], y[COMP_W-1:0], x[COMP_W-1:0]};
    return v;
  endfunction

  // Reference: exact integer difference, then wrap or clamp into range.
  function automatic exp_t model(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    exp_t m;
    logic signed [COMP_W-1:0] ca, cb;
    int d;
    m = '0;
    for (int k = 0; k < NUM_COMP; k++) begin
      ca = a[k*COMP_W +: COMP_W];
      cb = b[k*COMP_W +: COMP_W];
      d  = int'(ca) - int'(cb);
      if (d > MAXV || d < MINV) m.ovf[k] = 1'b1;
`ifdef VECTOR_SUB_SATURATE_EN
      if (d > MAXV) d = MAXV;
      if (d < MINV) d = MINV;
`else
      if (d > MAXV) d = d - (1 << COMP_W);
      if (d < MINV) d = d + (1 << COMP_W);
`endif
      m.vec[k*COMP_W +: COMP_W] = d[COMP_W-1:0];
    end
    return m;
  endfunction

  function automatic logic [COMP_W-1:0] rcomp();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0: return MAXV[COMP_W-1:0];
      1: return MINV[COMP_W-1:0];
      2: return '0;
      3: return '1;
      default: return r[COMP_W-1:0];
    endcase
  endfunction

  // Present one pair (entered and left at posedge+1); push its result on accept.
  task automatic send(input logic [VEC_W-1:0] a, input logic [VEC_W-1:0] b);
    bit got;
    got = 0;
    in_vector_1 = a;
    in_vector_2 = b;
    in_valid = 1'b1;
    for (int t = 0; t < 200 && !got; t++) begin
      @(negedge clk);
      if (in_ready) begin
        q.push_back(model(a, b));
        got = 1;
      end
      @(posedge clk);
      #1;
    end
    if (!got) chk("accept_timeout", 64'd0, 64'd1);
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int t = 0; t < 100 && q.size() != 0; t++) @(posedge clk);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask

  // Monitor: status compare every cycle, scoreboard compare on each transfer.
  always @(negedge clk) begin
    exp_t e;
    chk("vec_count", 64'(vec_count), 64'(exp_count));
    chk("ovf_sticky", 64'(ovf_sticky), 64'(exp_sticky));
    if (out_valid && out_ready) begin
      if (q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_output actual=%0h required=none", out_vector);
        e = '0;
      end else begin
        e = q.pop_front();
        chk("out_vector", 64'(out_vector), 64'(e.vec));
        chk("out_ovf", 64'(out_ovf), 64'(e.ovf));
      end
      exp_count = exp_count + 1'b1;
      if (|e.ovf) exp_sticky = 1'b1;
      else if (clr_sticky) exp_sticky = 1'b0;
    end else if (clr_sticky) begin
      exp_sticky = 1'b0;
    end
  end

  initial begin
    logic [VEC_W-1:0] held;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    chk("rst_out_vector", 64'(out_vector), 64'd0);
    chk("rst_out_ovf", 64'(out_ovf), 64'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Directed: basic, positive overflow on x, negative overflow on y.
    send(pack(100, -5, 0), pack(30, 10, -7));
    send(pack(MAXV, 0, 0), pack(-1, 0, 0));
    send(pack(0, MINV, 0), pack(0, 1, 0));
    drain();

    // Backpressure: 5 vectors while out_ready drops for 4 cycles.
    @(posedge clk);
    #1;
    fork
      begin
        for (int i = 1; i <= 5; i++) send(pack(i, i, i), pack(1, 1, 1));
      end
      begin
        repeat (2) @(posedge clk);
        #1;
        out_ready = 1'b0;
        @(negedge clk);
        held = out_vector;
        for (int c = 0; c < 3; c++) begin
          @(negedge clk);
          chk("stall_in_ready", 64'(in_ready), 64'd0);
          chk("stall_out_valid", 64'(out_valid), 64'd1);
          chk("stall_hold", 64'(out_vector), 64'(held));
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();

    // Sticky: clear collides with an overflowing transfer, then a lone clear.
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    send(pack(MAXV, 0, 0), pack(-1, 0, 0));
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_set_wins", 64'(ovf_sticky), 64'd1);
    @(posedge clk);
    #1;
    clr_sticky = 1'b1;
    @(posedge clk);
    #1;
    clr_sticky = 1'b0;
    chk("sticky_cleared", 64'(ovf_sticky), 64'd0);

    // Randomized stream with random backpressure.
    rand_done = 0;
    fork
      begin
        for (int n = 0; n < 200; n++) begin
          if ($urandom_range(0, 3) == 0) begin
            @(posedge clk);
            #1;
          end
          send({rcomp(), rcomp(), rcomp()}, {rcomp(), rcomp(), rcomp()});
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          out_ready = ($urandom_range(0, 2) != 0);
          @(posedge clk);
          #1;
        end
      end
    join
    out_ready = 1'b1;
    drain();

    // Reset with two vectors held in the pipeline.
    out_ready = 1'b0;
    send(pack(9, 9, 9), pack(1, 2, 3));
    send(pack(7, 7, 7), pack(1, 1, 1));
    @(posedge clk);
    #3;
    rst = 1'b1;
    q.delete();
    exp_count = '0;
    exp_sticky = 1'b0;
    #1;
    chk("midrst_out_valid", 64'(out_valid), 64'd0);
    chk("midrst_vec_count", 64'(vec_count), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    chk("midrst_in_ready", 64'(in_ready), 64'd1);
    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    chk("midrst_no_stale", 64'(out_valid), 64'd0);
    send(pack(5, 6, 7), pack(1, 1, 1));
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
